// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding, default timing constants and reset values for the PLL lock sequencer
package pll_seq_pkg;
  localparam int CNT_W             = 24;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 270000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam logic [3:0] PSDA_RST   = 4'b0000;
  localparam logic [3:0] DUTYDA_RST = 4'b1000;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, SETTLE, ACK} state_e;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer bringing the asynchronous PLL LOCK into the clk domain
//   clk, rst_n : reference clock, asynchronous active-low reset (flops clear to 0)
//   async_i    : asynchronous input
//   sync_o     : second-stage synchronized output
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else ff_q <= {ff_q[0], async_i};
  assign sync_o = ff_q[1];
endmodule

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL reset/lock sequencer with lock qualification, retry and phase/duty update handshake
//   clk, rst_n              : PLL reference clock, asynchronous active-low reset
//   pll_lock                : PLL LOCK (asynchronous)
//   pll_reset, psda, dutyda : PLL RESET, phase and duty controls
//   sys_rst_n, locked       : downstream reset (high only while usable), synchronized lock
//   ph_req/ph_psda/ph_dutyda: level update request with requested phase/duty
//   ph_ack                  : one-cycle update-complete pulse
//   retry_cnt               : saturating count of PLL reset retries
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic       sys_rst_n,
  output logic       locked,
  input  logic       ph_req,
  input  logic [3:0] ph_psda,
  input  logic [3:0] ph_dutyda,
  output logic       ph_ack,
  output logic [7:0] retry_cnt
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] psda_q, psda_d, dutyda_q, dutyda_d;
  logic [7:0] retry_q, retry_d;
  logic pll_reset_q, sys_rst_n_q, ph_ack_q;
  logic lock_s;
  pll_lock_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pll_lock),
    .sync_o  (lock_s)
  );
  // The lock_s cycle seen in WAIT_LOCK is the first of the STABLE_CYCLES
  // consecutive locked cycles, so STABLE itself needs one cycle fewer and
  // release lands exactly STABLE_CYCLES cycles after lock_s rises.
  always_comb begin
    state_d  = state_q;
    psda_d   = psda_q;
    dutyda_d = dutyda_q;
    case (state_q)
      RESET_PLL: state_d = (cnt_q == CNT_W'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: state_d = lock_s ? STABLE : (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) ? RESET_PLL : WAIT_LOCK;
      STABLE:    state_d = !lock_s ? WAIT_LOCK : (cnt_q + CNT_W'(2) >= CNT_W'(STABLE_CYCLES)) ? RUN : STABLE;
      RUN:
        if (!lock_s) state_d = RESET_PLL;
        else if (ph_req) begin
          state_d  = SETTLE;
          psda_d   = ph_psda;
          dutyda_d = ph_dutyda;
        end
      SETTLE:    state_d = !lock_s ? RESET_PLL : (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? ACK : SETTLE;
      ACK:       state_d = RUN;
      default:   state_d = RESET_PLL;
    endcase
    cnt_d   = (state_d == state_q) ? cnt_q + 1'b1 : '0;
    retry_d = (state_d == RESET_PLL && state_q != RESET_PLL) ? sat_inc(retry_q) : retry_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      psda_q      <= PSDA_RST;
      dutyda_q    <= DUTYDA_RST;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ph_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psda_q      <= psda_d;
      dutyda_q    <= dutyda_d;
      retry_q     <= retry_d;
      pll_reset_q <= state_d == RESET_PLL;
      sys_rst_n_q <= state_d inside {RUN, SETTLE, ACK};
      ph_ack_q    <= state_d == ACK;
    end
  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ph_ack    = ph_ack_q;
  assign psda      = psda_q;
  assign dutyda    = dutyda_q;
  assign retry_cnt = retry_q;
  assign locked    = lock_s;
endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: vector table, directed corner sequences and randomized run against a timer-based reference model
module tb_pll_lock_seq;
  localparam int RST = 4, LOCK_TO = 100, STAB = 8, SETTLE = 4;
  logic clk = 1'b0, rst_n = 1'b0, pll_lock = 1'b0, ph_req = 1'b0;
  logic [3:0] ph_psda = 4'h0, ph_dutyda = 4'h0;
  logic pll_reset, sys_rst_n, locked, ph_ack;
  logic [3:0] psda, dutyda;
  logic [7:0] retry_cnt;
  int checks = 0, errors = 0;
  pll_lock_seq #(.RST_CYCLES(RST), .LOCK_TIMEOUT(LOCK_TO), .STABLE_CYCLES(STAB), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(pll_reset), .psda(psda), .dutyda(dutyda),
    .sys_rst_n(sys_rst_n), .locked(locked), .ph_req(ph_req), .ph_psda(ph_psda), .ph_dutyda(ph_dutyda),
    .ph_ack(ph_ack), .retry_cnt(retry_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [19:0] outs();
    return {pll_reset, sys_rst_n, locked, ph_ack, psda, dutyda, retry_cnt};
  endfunction
  function automatic logic [19:0] ex(input logic pr, input logic sy, input logic lk, input logic ak,
                                     input logic [3:0] ps, input logic [3:0] du, input logic [7:0] rc);
    return {pr, sy, lk, ak, ps, du, rc};
  endfunction
  // reference model: phases with down-counting "cycles left" timers
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_SET = 4, M_ACK = 5;
  int m_mode, m_left, m_retry;
  bit [1:0] m_sh;
  bit m_ls;
  logic [3:0] m_psda, m_duty;
  task automatic m_retry_reset();
    m_mode  = M_RST;
    m_left  = RST;
    m_retry = (m_retry < 255) ? m_retry + 1 : 255;
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_RST; m_left = RST; m_retry = 0; m_sh = 2'b00; m_psda = 4'h0; m_duty = 4'h8;
    end else begin
      m_ls = m_sh[1];
      m_sh = {m_sh[0], pll_lock};
      case (m_mode)
        M_RST: begin m_left--; if (m_left == 0) begin m_mode = M_WAIT; m_left = LOCK_TO; end end
        M_WAIT:
          if (m_ls) begin m_mode = M_STAB; m_left = STAB - 1; end
          else begin m_left--; if (m_left == 0) m_retry_reset(); end
        M_STAB:
          if (!m_ls) begin m_mode = M_WAIT; m_left = LOCK_TO; end
          else begin m_left--; if (m_left == 0) m_mode = M_RUN; end
        M_RUN:
          if (!m_ls) m_retry_reset();
          else if (ph_req) begin m_psda = ph_psda; m_duty = ph_dutyda; m_mode = M_SET; m_left = SETTLE; end
        M_SET:
          if (!m_ls) m_retry_reset();
          else begin m_left--; if (m_left == 0) m_mode = M_ACK; end
        default: m_mode = M_RUN;
      endcase
    end
  end
  function automatic logic [19:0] m_outs();
    return {m_mode == M_RST, m_mode >= M_RUN, m_sh[1], m_mode == M_ACK, m_psda, m_duty, 8'(m_retry)};
  endfunction
  typedef struct {
    logic rst_n; logic lock; logic req; logic [3:0] ps; logic [3:0] du; int n; logic [19:0] exp;
  } vec_t;
  vec_t tbl[$];
  int last_rise, rises, lock_left;
  logic prev_pr;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2, ex(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3, ex(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1, ex(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 6, ex(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1, ex(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1, ex(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 7, ex(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h8, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 1, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 4'h6, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 3, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 4'h6, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 1, ex(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 4'h6, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 1, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h3, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h7, 4'h1, 4, ex(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h7, 4'h1, 1, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h3, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h7, 4'h1, 1, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 4'h1, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4, ex(1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 4'h1, 8'd0)});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1, ex(1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 4'h1, 8'd0)});
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; pll_lock = tbl[i].lock; ph_req = tbl[i].req;
      ph_psda = tbl[i].ps; ph_dutyda = tbl[i].du;
      repeat (tbl[i].n) @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    // lock lost while settling: no ack, one retry, phase/duty retained
    ph_req = 1'b1; ph_psda = 4'h5; ph_dutyda = 4'h6;
    @(negedge clk);
    chk("settle_psda", 32'(psda), 32'h5);
    ph_req = 1'b0; pll_lock = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("settle_noack", 32'(ph_ack), 32'h0);
    end
    chk("drop_sys", 32'(sys_rst_n), 32'h0);
    chk("drop_pllrst", 32'(pll_reset), 32'h1);
    chk("drop_retry", 32'(retry_cnt), 32'h1);
    repeat (10) begin
      @(negedge clk);
      chk("drop_keep", 32'({ph_ack, psda, dutyda}), 32'({1'b0, 4'h5, 4'h6}));
    end
    // one-cycle lock glitch during STABLE restarts the full qualification
    rst_n = 1'b0; pll_lock = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("glitch_sys%0d", k), 32'(sys_rst_n), 32'(k >= 17));
      if (k == 6) pll_lock = 1'b0;
      if (k == 7) pll_lock = 1'b1;
    end
    // asynchronous reset in RUN takes effect within the cycle
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("arst_run", 32'(outs()), 32'(ex(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'd0)));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rerun_sys", 32'(sys_rst_n), 32'h1);
    ph_req = 1'b1; ph_psda = 4'h9; ph_dutyda = 4'h2;
    @(negedge clk);
    chk("rerun_psda", 32'({psda, dutyda}), 32'h92);
    ph_req = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("arst_settle", 32'(outs()), 32'(ex(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'd0)));
    @(negedge clk);
    rst_n = 1'b1; ph_req = 1'b1; ph_psda = 4'hF; ph_dutyda = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("abort_noack", 32'(ph_ack), 32'h0);
      chk("abort_pllrst", 32'(pll_reset), 32'(k < RST));
      chk("abort_ignore_req", 32'({psda, dutyda}), 32'h08);
    end
    ph_req = 1'b0;
    // lock never arrives: retries every RST+LOCK_TO cycles, saturating counter
    rst_n = 1'b0; pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; last_rise = 0; rises = 0; prev_pr = 1'b1;
    for (int k = 1; k <= 260 * (RST + LOCK_TO) + 10; k++) begin
      @(negedge clk);
      if (pll_reset && !prev_pr) begin
        rises++;
        chk("retry_period", 32'(k - last_rise), 32'(RST + LOCK_TO));
        chk("retry_cnt", 32'(retry_cnt), 32'((rises < 255) ? rises : 255));
        last_rise = k;
      end
      if (!pll_reset && prev_pr) chk("retry_width", 32'(k - last_rise), 32'(RST));
      prev_pr = pll_reset;
    end
    chk("retry_rises", 32'(rises), 32'd260);
    chk("retry_sat", 32'(retry_cnt), 32'd255);
    // randomized run against the reference model
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; lock_left = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      chk("model", 32'(outs()), 32'(m_outs()));
      if (lock_left == 0) begin
        pll_lock  = ($urandom_range(0, 9) < 7);
        lock_left = pll_lock ? $urandom_range(5, 80)
                             : (($urandom_range(0, 3) == 0) ? $urandom_range(100, 250) : $urandom_range(1, 4));
      end else lock_left--;
      ph_req    = ($urandom_range(0, 3) == 0);
      ph_psda   = 4'($urandom);
      ph_dutyda = 4'($urandom);
      rst_n     = ($urandom_range(0, 999) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
